pair_reduce_pipe: RTL

Parametrised, pipelined successor to the four-bit pair-combine block. It splits a WIDTH-bit input word into adjacent bit pairs and combines each pair with a runtime-selectable logic operation. It then OR-reduces the pair results through a registered binary tree to one output bit. Transfers use a valid/ready handshake, and a saturating counter tallies delivered results equal to 1. The block sits between a word source and any single-bit consumer that may apply backpressure.

---
 rtl/pair_reduce_pipe.sv | 104 ++++++++++
 1 files changed

// File: rtl/pair_reduce_pipe.sv
// pair_reduce_pipe: combines adjacent bit pairs of a word with a selectable
// logic op, OR-reduces the pair results through a registered tree, and
// delivers one bit per word over a valid/ready handshake. A saturating
// counter tallies delivered ones.
module pair_reduce_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out1,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             hit_clr,
    output logic [CNT_W-1:0] hit_cnt
);

    // Tree geometry: stage s holds HALF >> s nodes; all stages packed
    // back-to-back into one vector, stage s starting at WIDTH - (WIDTH >> s).
    localparam int unsigned L     = $clog2(WIDTH);
    localparam int unsigned HALF  = WIDTH / 2;
    localparam int unsigned NODES = WIDTH - 1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             adv_c;
    logic             acc_c;
    logic [NODES-1:0] tree_q;
    logic [NODES-1:0] tree_d;
    logic [L-1:0]     vld_q;
    logic [L-1:0]     vld_d;
    logic [CNT_W-1:0] hit_q;
    logic [CNT_W-1:0] hit_d;

    // Pair operation selected by mode: AND, OR, XOR, NAND.
    function automatic logic pair_op(input logic a, input logic b, input logic [1:0] op);
        logic r;
        r = 1'b0;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = ~(a & b);
        endcase
        return r;
    endfunction

    // The whole pipe moves unless a valid output is being held.
    assign adv_c    = ~vld_q[L-1] | out_ready;
    assign in_ready = adv_c;
    assign acc_c    = in_valid & adv_c;

    // Stage 0: pair results load only on accept; otherwise data holds.
    for (genvar k = 0; k < HALF; k++) begin : g_pair
        assign tree_d[k] = acc_c ? pair_op(in1[2*k+1], in1[2*k], mode) : tree_q[k];
    end

    // Stage 0 valid: set on accept, bubble when advancing without accept.
    assign vld_d[0] = adv_c ? acc_c : vld_q[0];

    // Stages 1..L-1: OR adjacent nodes of the previous stage when advancing.
    for (genvar s = 1; s < L; s++) begin : g_lvl
        localparam int unsigned N   = HALF >> s;
        localparam int unsigned SRC = WIDTH - (WIDTH >> (s - 1));
        localparam int unsigned DST = WIDTH - (WIDTH >> s);
        for (genvar k = 0; k < N; k++) begin : g_node
            assign tree_d[DST+k] = adv_c ? (tree_q[SRC+2*k] | tree_q[SRC+2*k+1])
                                         : tree_q[DST+k];
        end
        assign vld_d[s] = adv_c ? vld_q[s-1] : vld_q[s];
    end

    // Hit counter next state: clear beats a saturating increment on delivery of a 1.
    always_comb begin
        hit_d = hit_q;
        if (hit_clr) begin
            hit_d = '0;
        end else if (vld_q[L-1] && out_ready && tree_q[NODES-1] && (hit_q != CNT_MAX)) begin
            hit_d = hit_q + CNT_W'(1);
        end
    end

    // State registers for the tree data, stage valids and hit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tree_q <= '0;
            vld_q  <= '0;
            hit_q  <= '0;
        end else begin
            tree_q <= tree_d;
            vld_q  <= vld_d;
            hit_q  <= hit_d;
        end
    end

    assign out1      = tree_q[NODES-1];
    assign out_valid = vld_q[L-1];
    assign hit_cnt   = hit_q;

endmodule
